// File: rtl/noc_local_ni_pkg.sv
// Shared definitions for the mesh-node network interface: flit layout,
// TX FSM states and the flit packing helper.
package noc_local_ni_pkg;

   localparam int unsigned DATA_WIDTH  = 32;

   localparam int unsigned DST_LSB     = 0;
   localparam int unsigned DST_W       = 3;
   localparam int unsigned SRC_LSB     = 3;
   localparam int unsigned SRC_W       = 3;
   localparam int unsigned SEQ_LSB     = 6;
   localparam int unsigned SEQ_W       = 8;
   localparam int unsigned PAYLOAD_LSB = 14;
   localparam int unsigned PAYLOAD_W   = 18;

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_WAIT = 2'd1,
      T_SEND = 2'd2
   } tx_state_t;

   typedef logic [DATA_WIDTH-1:0] flit_t;

   function automatic flit_t pack_flit(input logic [PAYLOAD_W-1:0] payload,
                                       input logic [SEQ_W-1:0]     seq,
                                       input logic [SRC_W-1:0]     src,
                                       input logic [DST_W-1:0]     dst);
      return {payload, seq, src, dst};
   endfunction

endpackage

// File: rtl/ni_rx_checker.sv
// RX sequence/destination checker: tracks the next expected seq per source
// node and counts (saturating) flits that are misrouted or out of order.
module ni_rx_checker
   import noc_local_ni_pkg::*;
#(
   parameter logic [SRC_W-1:0] NI_ADDRESS = 3'b000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flit_valid,
   input  logic [DST_W-1:0] flit_dst,
   input  logic [SRC_W-1:0] flit_src,
   input  logic [SEQ_W-1:0] flit_seq,
   output logic [7:0]       err_count
);

   localparam int unsigned NODES = 1 << SRC_W;

   logic [SEQ_W-1:0] expected [NODES];
   logic             err;

   always_comb begin
      err = (flit_dst != NI_ADDRESS) || (flit_seq != expected[flit_src]);
   end

   // The table resyncs on every flit so one gap costs a single error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NODES; i++) begin
            expected[i] <= '0;
         end
         err_count <= '0;
      end else if (flit_valid) begin
         expected[flit_src] <= flit_seq + SEQ_W'(1);
         if (err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: rtl/noc_local_ni.sv
// Local network interface between a PE and the router local port.
// Optional RX checking is enabled by defining NOC_NI_RX_CHECK_EN.
module noc_local_ni
   import noc_local_ni_pkg::*;
#(
   parameter logic [SRC_W-1:0] NI_ADDRESS = 3'b000,
   parameter int unsigned      CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [DST_W-1:0]      tx_dst,
   input  logic [PAYLOAD_W-1:0]  tx_payload,
   output logic [DATA_WIDTH-1:0] ROUTER_DATA_OUT,
   output logic                  ROUTER_DATA_VALID_OUT,
   input  logic                  ROUTER_FULL_IN,
   input  logic [DATA_WIDTH-1:0] ROUTER_DATA_IN,
   input  logic                  ROUTER_DATA_VALID_IN,
   output logic                  rx_valid,
   output logic [SRC_W-1:0]      rx_src,
   output logic [SEQ_W-1:0]      rx_seq,
   output logic [PAYLOAD_W-1:0]  rx_payload,
   output logic [CNT_W-1:0]      tx_count,
   output logic [CNT_W-1:0]      rx_count,
   output logic [7:0]            rx_err_count
);

   tx_state_t        state_q, state_d;
   flit_t            hold_q, hold_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   flit_t            data_d;
   logic             valid_d;
   logic [CNT_W-1:0] tx_count_d;

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      seq_d      = seq_q;
      data_d     = ROUTER_DATA_OUT;
      valid_d    = 1'b0;
      tx_count_d = tx_count;
      unique case (state_q)
         T_IDLE: begin
            if (tx_ready && tx_valid) begin
               hold_d  = pack_flit(tx_payload, seq_q, NI_ADDRESS, tx_dst);
               seq_d   = seq_q + SEQ_W'(1);
               state_d = T_WAIT;
            end
         end
         T_WAIT: begin
            if (!ROUTER_FULL_IN) begin
               data_d  = hold_q;
               valid_d = 1'b1;
               state_d = T_SEND;
            end
         end
         T_SEND: begin
            data_d     = '0;
            tx_count_d = tx_count + CNT_W'(1);
            state_d    = T_IDLE;
         end
         default: state_d = T_IDLE;
      endcase
   end

   // tx_ready is registered so it reads 0 in the cycle after reset,
   // while still being high for every cycle spent in T_IDLE afterwards.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q               <= T_IDLE;
         hold_q                <= '0;
         seq_q                 <= '0;
         tx_ready              <= 1'b0;
         ROUTER_DATA_OUT       <= '0;
         ROUTER_DATA_VALID_OUT <= 1'b0;
         tx_count              <= '0;
      end else begin
         state_q               <= state_d;
         hold_q                <= hold_d;
         seq_q                 <= seq_d;
         tx_ready              <= (state_d == T_IDLE);
         ROUTER_DATA_OUT       <= data_d;
         ROUTER_DATA_VALID_OUT <= valid_d;
         tx_count              <= tx_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_valid   <= 1'b0;
         rx_src     <= '0;
         rx_seq     <= '0;
         rx_payload <= '0;
         rx_count   <= '0;
      end else begin
         rx_valid <= ROUTER_DATA_VALID_IN;
         if (ROUTER_DATA_VALID_IN) begin
            rx_src     <= ROUTER_DATA_IN[SRC_LSB +: SRC_W];
            rx_seq     <= ROUTER_DATA_IN[SEQ_LSB +: SEQ_W];
            rx_payload <= ROUTER_DATA_IN[PAYLOAD_LSB +: PAYLOAD_W];
            rx_count   <= rx_count + CNT_W'(1);
         end
      end
   end

`ifdef NOC_NI_RX_CHECK_EN
   ni_rx_checker #(
      .NI_ADDRESS (NI_ADDRESS)
   ) u_rx_checker (
      .clk        (clk),
      .rst_n      (rst_n),
      .flit_valid (ROUTER_DATA_VALID_IN),
      .flit_dst   (ROUTER_DATA_IN[DST_LSB +: DST_W]),
      .flit_src   (ROUTER_DATA_IN[SRC_LSB +: SRC_W]),
      .flit_seq   (ROUTER_DATA_IN[SEQ_LSB +: SEQ_W]),
      .err_count  (rx_err_count)
   );
`else
   logic [DST_W-1:0] unused_dst;
   assign unused_dst   = ROUTER_DATA_IN[DST_LSB +: DST_W];
   assign rx_err_count = '0;
`endif

endmodule

// File: tb/tb_noc_local_ni.sv
// Directed + randomized bench for noc_local_ni against a queue/array model.
module tb_noc_local_ni;

   localparam logic [2:0] NI = 3'd3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tx_valid;
   logic        tx_ready;
   logic [2:0]  tx_dst;
   logic [17:0] tx_payload;
   logic [31:0] ROUTER_DATA_OUT;
   logic        ROUTER_DATA_VALID_OUT;
   logic        ROUTER_FULL_IN;
   logic [31:0] ROUTER_DATA_IN;
   logic        ROUTER_DATA_VALID_IN;
   logic        rx_valid;
   logic [2:0]  rx_src;
   logic [7:0]  rx_seq;
   logic [17:0] rx_payload;
   logic [15:0] tx_count;
   logic [15:0] rx_count;
   logic [7:0]  rx_err_count;

   noc_local_ni #(
      .NI_ADDRESS (NI),
      .CNT_W      (16)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .tx_valid              (tx_valid),
      .tx_ready              (tx_ready),
      .tx_dst                (tx_dst),
      .tx_payload            (tx_payload),
      .ROUTER_DATA_OUT       (ROUTER_DATA_OUT),
      .ROUTER_DATA_VALID_OUT (ROUTER_DATA_VALID_OUT),
      .ROUTER_FULL_IN        (ROUTER_FULL_IN),
      .ROUTER_DATA_IN        (ROUTER_DATA_IN),
      .ROUTER_DATA_VALID_IN  (ROUTER_DATA_VALID_IN),
      .rx_valid              (rx_valid),
      .rx_src                (rx_src),
      .rx_seq                (rx_seq),
      .rx_payload            (rx_payload),
      .tx_count              (tx_count),
      .rx_count              (rx_count),
      .rx_err_count          (rx_err_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // TX model: next seq, injected-flit count, flits awaiting injection
   int          m_seq;
   int          m_txcnt;
   logic [31:0] txq [$];

   // RX model: what the PE side should show after each edge
   logic        m_rxv;
   logic [2:0]  m_src;
   logic [7:0]  m_rseq;
   logic [17:0] m_pay;
   int          m_rxcnt;
   int          m_err;
   int          exp_tab [8];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [2:0] dst, input logic [2:0] src,
                                      input logic [7:0] seq, input logic [17:0] pay);
      return {pay, seq, src, dst};
   endfunction

   task automatic rx_idle();
      ROUTER_DATA_VALID_IN = 1'b0;
      ROUTER_DATA_IN       = $urandom;
   endtask

   task automatic rx_rand();
      ROUTER_DATA_VALID_IN = 1'($urandom_range(0, 1));
      ROUTER_DATA_IN       = $urandom;
   endtask

   task automatic rx_flit(input logic [2:0] dst, input logic [2:0] src, input logic [7:0] seq);
      ROUTER_DATA_VALID_IN = 1'b1;
      ROUTER_DATA_IN       = mk(dst, src, seq, 18'($urandom));
   endtask

   // One clock: update the RX model from the inputs seen at the edge, then check RX side.
   task automatic tick();
      logic [31:0] f;
      @(posedge clk);
      f = ROUTER_DATA_IN;
      if (!rst_n) begin
         m_rxv = 1'b0; m_src = '0; m_rseq = '0; m_pay = '0;
         m_rxcnt = 0; m_err = 0;
         for (int i = 0; i < 8; i++) exp_tab[i] = 0;
      end else begin
         m_rxv = ROUTER_DATA_VALID_IN;
         if (ROUTER_DATA_VALID_IN) begin
            m_src   = f[5:3];
            m_rseq  = f[13:6];
            m_pay   = f[31:14];
            m_rxcnt = (m_rxcnt + 1) % 65536;
`ifdef NOC_NI_RX_CHECK_EN
            if ((f[2:0] != NI) || (int'(f[13:6]) != exp_tab[f[5:3]]))
               m_err = (m_err < 255) ? m_err + 1 : 255;
            exp_tab[f[5:3]] = (int'(f[13:6]) + 1) % 256;
`endif
         end
      end
      #1;
      chk("rx_out", {rx_valid, rx_src, rx_seq, rx_payload}, {m_rxv, m_src, m_rseq, m_pay});
      chk("rx_count", rx_count, 16'(m_rxcnt));
      chk("rx_err_count", rx_err_count, 8'(m_err));
   endtask

   task automatic tx_wait_ready();
      int n = 0;
      while (!tx_ready && n < 10) begin
         tick();
         n++;
      end
      chk("tx_ready_timeout", tx_ready, 1'b1);
   endtask

   task automatic send_one(input logic [2:0] dst, input logic [17:0] pay, input int full_cycles);
      logic [31:0] exp;
      bit          ok = 1'b1;
      tx_wait_ready();
      exp = mk(dst, NI, 8'(m_seq), pay);
      tx_valid = 1'b1; tx_dst = dst; tx_payload = pay;
      tick();
      m_seq++;
      tx_valid = 1'b0; tx_dst = 3'($urandom); tx_payload = 18'($urandom);
      chk("accept_ready", tx_ready, 1'b0);
      chk("accept_valid", ROUTER_DATA_VALID_OUT, 1'b0);
      if (full_cycles > 0) begin
         ROUTER_FULL_IN = 1'b1;
         for (int i = 0; i < full_cycles; i++) begin
            tick();
            if (ROUTER_DATA_VALID_OUT !== 1'b0 || tx_ready !== 1'b0) ok = 1'b0;
         end
         chk("backpressure_hold", ok, 1'b1);
         ROUTER_FULL_IN = 1'b0;
      end
      tick();
      chk("inject_valid", ROUTER_DATA_VALID_OUT, 1'b1);
      chk("inject_data", ROUTER_DATA_OUT, exp);
      tick();
      m_txcnt = (m_txcnt + 1) % 65536;
      chk("post_valid", ROUTER_DATA_VALID_OUT, 1'b0);
      chk("post_data", ROUTER_DATA_OUT, 32'h0);
      chk("tx_count", tx_count, 16'(m_txcnt));
   endtask

   // tx_valid held high for n flits; ready every 3rd cycle, valid two cycles after accept.
   task automatic run_tx(input int n);
      logic [31:0] exp;
      int          acc = 0;
      for (int i = 0; i < 3 * n; i++) begin
         chk("tx_ready_pattern", tx_ready, (i % 3 == 0));
         chk("tx_valid_pattern", ROUTER_DATA_VALID_OUT, (i % 3 == 2));
         exp = 32'h0;
         if (i % 3 == 2) exp = (txq.size() > 0) ? txq.pop_front() : 32'hFFFF_FFFF;
         chk("tx_stream_data", ROUTER_DATA_OUT, exp);
         if (i % 3 == 0 && acc < n) begin
            tx_valid   = 1'b1;
            tx_dst     = 3'($urandom_range(0, 7));
            tx_payload = 18'($urandom);
            txq.push_back(mk(tx_dst, NI, 8'(m_seq), tx_payload));
            m_seq++;
            acc++;
         end
         rx_rand();
         tick();
      end
      tx_valid = 1'b0;
      rx_idle();
      tick();
      m_txcnt = (m_txcnt + n) % 65536;
      chk("stream_tx_count", tx_count, 16'(m_txcnt));
      chk("stream_queue_empty", txq.size(), 0);
   endtask

   initial begin
      bit ok;
      rst_n = 1'b0; tx_valid = 1'b0; tx_dst = '0; tx_payload = '0;
      ROUTER_FULL_IN = 1'b0;
      rx_idle();
      m_seq = 0; m_txcnt = 0;
      repeat (3) tick();
      chk("reset_tx", {tx_ready, ROUTER_DATA_VALID_OUT, ROUTER_DATA_OUT, tx_count}, 50'h0);

      rst_n = 1'b1;
      tick();
      chk("ready_after_reset", tx_ready, 1'b1);

      // single send with literal expectation
      tx_valid = 1'b1; tx_dst = 3'd5; tx_payload = 18'h2ABCD;
      tick();
      m_seq++;
      tx_valid = 1'b0;
      chk("single_accept_valid", ROUTER_DATA_VALID_OUT, 1'b0);
      tick();
      chk("single_valid", ROUTER_DATA_VALID_OUT, 1'b1);
      chk("single_data", ROUTER_DATA_OUT, 32'hAAF3401D);
      tick();
      m_txcnt++;
      chk("single_one_pulse", ROUTER_DATA_VALID_OUT, 1'b0);
      chk("single_tx_count", tx_count, 16'd1);

      send_one(3'd6, 18'h15555, 20);
      send_one(NI, 18'h3FFFF, 0);

      run_tx(10);
      run_tx(250);

      // RX directed: src 2 seq 7, then a back-to-back burst
      rx_flit(NI, 3'd2, 8'd7);
      tick();
      chk("rx_src2_seq7", {rx_valid, rx_src, rx_seq}, {1'b1, 3'd2, 8'd7});
      for (int i = 0; i < 20; i++) begin
         ROUTER_DATA_VALID_IN = 1'b1;
         ROUTER_DATA_IN       = $urandom;
         tick();
      end
      rx_idle();
      tick();

      // reset while a flit is held in the wait state
      tx_wait_ready();
      tx_valid = 1'b1; tx_dst = 3'd1; tx_payload = 18'h12345;
      tick();
      tx_valid = 1'b0;
      ROUTER_FULL_IN = 1'b1;
      tick(); tick();
      rst_n = 1'b0;
      tick();
      chk("midreset_tx", {tx_ready, ROUTER_DATA_VALID_OUT, ROUTER_DATA_OUT, tx_count}, 50'h0);
      ROUTER_FULL_IN = 1'b0;
      tick();
      rst_n = 1'b1;
      m_seq = 0; m_txcnt = 0; txq.delete();
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ROUTER_DATA_VALID_OUT !== 1'b0) ok = 1'b0;
      end
      chk("held_flit_discarded", ok, 1'b1);
      send_one(3'd4, 18'h0AAAA, 0);

`ifdef NOC_NI_RX_CHECK_EN
      rx_flit(NI, 3'd1, 8'd0); tick();
      rx_flit(NI, 3'd1, 8'd1); tick();
      rx_flit(NI, 3'd1, 8'd3); tick();
      rx_idle(); tick();
      chk("chk_seq_gap", rx_err_count, 8'd1);
      rx_flit(3'(NI + 3'd1), 3'd1, 8'd4); tick();
      rx_idle(); tick();
      chk("chk_bad_dst", rx_err_count, 8'd2);
      for (int i = 0; i < 300; i++) begin
         rx_flit(3'(NI + 3'd2), 3'($urandom), 8'($urandom));
         tick();
      end
      rx_idle(); tick();
      chk("chk_saturate", rx_err_count, 8'd255);
`else
      for (int i = 0; i < 10; i++) begin
         rx_flit(3'(NI + 3'd1), 3'd1, 8'd9);
         tick();
      end
      rx_idle(); tick();
      chk("err_count_tied", rx_err_count, 8'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/noc_local_ni.md
Name: noc_local_ni

Overview:
- Network interface for one mesh node. Sits between a processing element and the router's local port.
- TX path: packs PE requests into 32-bit flits and injects them into the router local input. Injection obeys the router's local FIFO full flag.
- RX path: unpacks flits ejected from the router local output and presents them to the PE.
- Also keeps traffic counters for the node.

Parameters:
- NI_ADDRESS, 3'b000, node address. Placed in the flit src field and used for the RX destination check.
- CNT_W, 16, width of the tx/rx flit counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- tx_valid  in  1  PE has a flit to send.
- tx_ready  out  1  NI can accept a flit this cycle.
- tx_dst  in  3  destination node address.
- tx_payload  in  18  payload.
- ROUTER_DATA_OUT  out  `DATA_WIDTH  flit to the router local input.
- ROUTER_DATA_VALID_OUT  out  1  write strobe to the router local FIFO.
- ROUTER_FULL_IN  in  1  router local FIFO full.
- ROUTER_DATA_IN  in  `DATA_WIDTH  flit from the router local output.
- ROUTER_DATA_VALID_IN  in  1  flit valid from the router.
- rx_valid  out  1  received flit valid.
- rx_src  out  3  source node of the received flit.
- rx_seq  out  8  sequence number of the received flit.
- rx_payload  out  18  received payload.
- tx_count  out  CNT_W  flits injected.
- rx_count  out  CNT_W  flits received.
- rx_err_count  out  8  RX check errors (only with the optional feature; otherwise tied 0).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Flit format:
  - [2:0] dst
  - [5:3] src = NI_ADDRESS
  - [13:6] seq
  - [31:14] payload
- Reset values: all outputs 0, TX FSM in T_IDLE, seq counter 0, holding register 0.
- Reset mid-operation: a held flit is discarded and is never injected.
- TX FSM has three states:
  - T_IDLE: tx_ready=1. If tx_valid, latch {tx_payload, seq, NI_ADDRESS, tx_dst} into the holding register, increment seq (8-bit, wraps 255->0), go to T_WAIT.
  - T_WAIT: tx_ready=0. If ROUTER_FULL_IN==0 at the clock edge, register ROUTER_DATA_OUT=holding and ROUTER_DATA_VALID_OUT=1, go to T_SEND. Otherwise stay.
  - T_SEND: ROUTER_DATA_VALID_OUT is high for exactly this cycle. At the edge, clear VALID, clear ROUTER_DATA_OUT to 0, increment tx_count, go to T_IDLE.
- TX rate: at most one flit per 3 cycles. The T_IDLE gap guarantees ROUTER_FULL_IN reflects the previous write before the next decision, so no flit is ever written into a full FIFO.
- FULL held high: the flit waits in T_WAIT indefinitely. It is never dropped.
- TX latency: tx_valid accepted at edge k means VALID_OUT is high during cycle k+1 to k+2 (edge k+1 to edge k+2), provided FULL is low at edge k+1.
- RX path has no backpressure; every ROUTER_DATA_VALID_IN flit is accepted.
  - One-cycle latency: rx_valid, rx_src, rx_seq and rx_payload are registered from the input flit.
  - rx_valid=0 when no flit arrives; data fields hold their last value.
  - rx_count increments per flit.
- Counters tx_count and rx_count wrap modulo 2^CNT_W.
- Simultaneous TX inject and RX receive are fully independent.
- Loopback (tx_dst==NI_ADDRESS) is legal.

Optional Feature:
- Macro: NOC_NI_RX_CHECK_EN.
- Defined: RX keeps an 8-entry expected-seq table indexed by src, reset to 0. A received flit is an error if dst!=NI_ADDRESS or seq!=expected[src].
  - On error, rx_err_count increments, saturating at 255.
  - On every received flit, whether in error or not, expected[src] = rx seq + 1.
  - The flit is still delivered on rx_*.
- Not defined: no table, no checks, rx_err_count tied to 0.

Decomposition:
- Add to global.v:
  - flit field offsets and widths: DST, SRC, SEQ, PAYLOAD
  - TX FSM state encodings: T_IDLE, T_WAIT, T_SEND
- The RX check logic is a natural sub-module, ni_rx_checker, instantiated only under the macro.

Test Plan:
- Single send: NI_ADDRESS=3, tx_dst=5, payload=0x2ABCD, FULL=0 -> exactly one VALID_OUT pulse carrying 0xAAF3401D (payload 0x2ABCD, seq 0, src 3, dst 5) two edges after accept; tx_count=1.
- Backpressure: FULL=1 for 20 cycles while a flit is held -> VALID_OUT stays 0 and tx_ready stays 0. Drop FULL -> flit injected once, unchanged.
- Back-to-back sends: tx_valid held for 10 flits, FULL=0 -> tx_ready pattern is 1 every 3rd cycle, seq 0..9, tx_count=10. Seq wraps after 256 flits.
- RX path: ROUTER_DATA_VALID_IN pulses with src=2, seq=7 -> rx_valid one cycle later with matching fields; rx_count increments; back-to-back RX flits on consecutive cycles are all delivered.
- Reset mid-operation: assert rst_n=0 while in T_WAIT -> next edge shows all outputs 0 and the held flit is never emitted. After release, seq restarts at 0.
- With NOC_NI_RX_CHECK_EN:
  - src 1 seqs 0,1,3 -> rx_err_count=1.
  - A flit with dst!=NI_ADDRESS -> rx_err_count=2.
  - 300 errors -> rx_err_count saturates at 255.
